clkctrl_phi2_gen: RTL and testbench
===================================

Name: clkctrl_phi2_gen

Overview:
Parametrised successor to the fixed host/fast CPU clock switcher. It produces the CPU clock `clkout` by glitch-free switching between two sources:
- the host clock `lsclk_in`, retimed through a delay pipe with a runtime-selectable tap;
- an even-ratio division of `hsclk_in` (÷2 up to ÷2·2^DIV_W).

All control is in the `hsclk_in` domain. Switching is driven by an explicit FSM with a guard period. Sits between board clock inputs and the CPU PHI0 pin.

Parameters:
- DEL_PIPE_SZ, 4, number of delay-pipe stages sampling `lsclk_in`.
- DEL_SEL_W, 2, width of `delay_sel`. Tap index is clamped to DEL_PIPE_SZ-1.
- DEF_TAP, 1, tap used from reset until the first GUARD load.
- DIV_W, 2, width of `cpuclk_div_sel`. Divisor = 2·(`cpuclk_div_sel`+1).
- GUARD_CYC, 2, `hsclk_in` cycles with both enables low during a switch (≥1).
- SYNC_STAGES, 2, synchroniser depth on `hsclk_sel` (≥2).

Ports:
- hsclk_in  in  1  fast clock; all state is clocked on it.
- rst_b  in  1  reset, asynchronous, active-low.
- lsclk_in  in  1  host clock, asynchronous.
- hsclk_sel  in  1  1 = request HS clock, 0 = request LS clock. Asynchronous.
- delay_sel  in  DEL_SEL_W  delay-pipe tap select.
- cpuclk_div_sel  in  DIV_W  HS divider ratio select.
- hsclk_selected  out  1  HS clock currently driving `clkout`.
- lsclk_selected  out  1  LS clock currently driving `clkout`.
- switch_busy  out  1  FSM in a transition state.
- clkout  out  1  CPU clock.

Behaviour:
Datapath
- `del_q[0]` <= `lsclk_in` on posedge; `del_q[i]` <= `del_q[i-1]`. `lsclk_del` = `del_q[tap_q]`. Latency is tap_q+1 posedges.
- `clkout` = (`cpuclk` & `hs_en`) | (`lsclk_del` & `ls_en`). This is the only combinational clock path.

Divider (posedge)
- Counter counts 0..div_q. When it reaches div_q it wraps to 0 and `cpuclk` toggles.
- High and low phases are each div_q+1 cycles (50% duty).
- In GUARD: counter = 0, `cpuclk` = 0, div_q <= `cpuclk_div_sel`. Outside GUARD, div_q and tap_q are frozen; input changes are ignored until the next switch.

Enables (negedge `hsclk_in`)
- `hs_en` may change only when `cpuclk` = 0; it takes the value of `hs_req`.
- `ls_en` may change only when `lsclk_del` = 0; it takes the value of `ls_req`.
- Sources only change on posedge, so each enable changes in the middle of a low phase and cannot produce runt pulses.

FSM (posedge), input `sel_s` = synchronised `hsclk_sel`; `hs_en`/`ls_en` are sampled directly.
- LS_RUN: `ls_req`=1. If `sel_s`=1 → LS_OFF_WAIT.
- LS_OFF_WAIT: `ls_req`=0. When `ls_en`=0 → GUARD.
- GUARD: both req=0. Counter `gcnt` runs 0..GUARD_CYC-1, and tap_q <= clamp(`delay_sel`) is loaded here. On expiry:
  - `sel_s`=1 → HS_ON_WAIT;
  - `sel_s`=0 → LS_ON_WAIT.
  The target is re-evaluated at expiry, so a request reversed mid-switch returns cleanly.
- HS_ON_WAIT: `hs_req`=1. When `hs_en`=1 → HS_RUN.
- HS_RUN: `hs_req`=1. If `sel_s`=0 → HS_OFF_WAIT.
- HS_OFF_WAIT: `hs_req`=0. When `hs_en`=0 → GUARD.
- LS_ON_WAIT: `ls_req`=1. When `ls_en`=1 → LS_RUN.
- A stopped `lsclk_in` stalls LS_OFF_WAIT/LS_ON_WAIT indefinitely. There is no timeout.

Outputs
- `hsclk_selected` = (state==HS_RUN).
- `lsclk_selected` = (state==LS_RUN).
- `switch_busy` = not (LS_RUN or HS_RUN).
- `hsclk_selected` and `lsclk_selected` are never both 1.

Reset (async)
- state = LS_RUN, `ls_en`=1, `hs_en`=0, `del_q`=0, `cpuclk`=0, counter=0, tap_q=DEF_TAP, div_q=0, synchroniser=0.
- Outputs after reset: `lsclk_selected`=1, `hsclk_selected`=0, `switch_busy`=0, `clkout` = `lsclk_del`.
- Reset mid-switch or mid-HS forces this state immediately. `clkout` may be truncated by the reset itself; this is acceptable.

Invariants
- `hs_en` & `ls_en` is never 1.
- Every `clkout` high pulse is either a full `cpuclk` high phase or a full `lsclk_del` high phase.

Decomposition:
- Package `clkctrl_pkg`:
  - FSM state enum (7 states, 3-bit);
  - function `div_half(sel)` returning sel+1;
  - function `clamp_tap(sel, sz)`.
- Sub-module `clkctrl_hsdiv`: synchronous even divider with `clr` and `load` inputs, ratio input, `cpuclk` output.
- Synchroniser, delay pipe, enables and FSM live in the top module.

Test Plan:
1. Reset; `lsclk_in` 8-cycle square wave, DEF_TAP=1 → `clkout` equals `lsclk_in` delayed 2 posedges; `lsclk_selected`=1.
2. `hsclk_sel` 0→1, `cpuclk_div_sel`=1 → `ls_en` drops in an LS low phase, then ≥2 cycles of `clkout`=0, then `clkout` runs 2 high / 2 low; `hsclk_selected`=1, `switch_busy`=0.
3. HS ÷2 running, `hsclk_sel`→0 → `hs_en` drops with `cpuclk` low, GUARD, then LS resumes; a checker shows no `clkout` high pulse shorter than 1 `hsclk_in` cycle and no cycle with both enables set.
4. `hsclk_sel` pulses 1 then back to 0 before GUARD expires → FSM goes GUARD→LS_ON_WAIT→LS_RUN; HS never enabled.
5. `delay_sel`=3 changed while in LS_RUN → latency unchanged (2) until the next switch; after HS→LS round trip, latency = 4.
6. Assert `rst_b` during HS_RUN with `cpuclk` high → immediate `hs_en`=0, `ls_en`=1, state LS_RUN; on release, `clkout` tracks the delayed `lsclk_in`.

Source files
------------

// File: rtl/clkctrl_pkg.sv
// Shared types and helpers for the PHI2 clock generator.
package clkctrl_pkg;

    typedef enum logic [2:0] {
        LS_RUN      = 3'd0,
        LS_OFF_WAIT = 3'd1,
        GUARD       = 3'd2,
        HS_ON_WAIT  = 3'd3,
        HS_RUN      = 3'd4,
        HS_OFF_WAIT = 3'd5,
        LS_ON_WAIT  = 3'd6
    } clk_state_e;

    // Half-period of the HS divider in hsclk_in cycles.
    function automatic int unsigned div_half(input int unsigned sel);
        return sel + 32'd1;
    endfunction

    function automatic int unsigned clamp_tap(input int unsigned sel, input int unsigned sz);
        return (sel > sz - 32'd1) ? sz - 32'd1 : sel;
    endfunction

endpackage

// File: rtl/clkctrl_hsdiv.sv
// Even-ratio divider of hsclk_in with 50% duty; clr parks the output low.
module clkctrl_hsdiv
    import clkctrl_pkg::*;
#(
    parameter int unsigned DIV_W = 2
) (
    input  logic             hsclk_in,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             load,
    input  logic [DIV_W-1:0] ratio,
    output logic             cpuclk
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             cpuclk_q, cpuclk_d;

    always_comb begin
        div_d    = div_q;
        cnt_d    = cnt_q;
        cpuclk_d = cpuclk_q;
        if (load) begin
            div_d = ratio;
        end
        if (clr) begin
            cnt_d    = '0;
            cpuclk_d = 1'b0;
        end else if (32'(cnt_q) + 32'd1 == div_half(32'(div_q))) begin
            cnt_d    = '0;
            cpuclk_d = ~cpuclk_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            div_q    <= '0;
            cnt_q    <= '0;
            cpuclk_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            cpuclk_q <= cpuclk_d;
        end
    end

    assign cpuclk = cpuclk_q;

endmodule

// File: rtl/clkctrl_phi2_gen.sv
// Glitch-free CPU clock switcher between a retimed host clock and a divided
// hsclk_in, sequenced by a guard-period FSM in the hsclk_in domain.
module clkctrl_phi2_gen
    import clkctrl_pkg::*;
#(
    parameter int unsigned DEL_PIPE_SZ = 4,
    parameter int unsigned DEL_SEL_W   = 2,
    parameter int unsigned DEF_TAP     = 1,
    parameter int unsigned DIV_W       = 2,
    parameter int unsigned GUARD_CYC   = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 hsclk_in,
    input  logic                 rst_b,
    input  logic                 lsclk_in,
    input  logic                 hsclk_sel,
    input  logic [DEL_SEL_W-1:0] delay_sel,
    input  logic [DIV_W-1:0]     cpuclk_div_sel,
    output logic                 hsclk_selected,
    output logic                 lsclk_selected,
    output logic                 switch_busy,
    output logic                 clkout
);

    localparam int unsigned TAP_W  = (DEL_PIPE_SZ > 1) ? $clog2(DEL_PIPE_SZ) : 1;
    localparam int unsigned GCNT_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    clk_state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [DEL_PIPE_SZ-1:0]  del_q, del_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic [GCNT_W-1:0]       gcnt_q, gcnt_d;
    logic                    hs_en_q, hs_en_d;
    logic                    ls_en_q, ls_en_d;
    logic                    hs_sel_q, hs_sel_d;
    logic                    ls_sel_q, ls_sel_d;
    logic                    busy_q, busy_d;
    logic                    hs_req, ls_req;
    logic                    guard_c;
    logic                    sel_s;
    logic                    lsclk_del;
    logic                    cpuclk;

    assign sel_s     = sync_q[SYNC_STAGES-1];
    assign lsclk_del = del_q[tap_q];
    assign guard_c   = (state_q == GUARD);

    clkctrl_hsdiv #(.DIV_W(DIV_W)) u_hsdiv (
        .hsclk_in (hsclk_in),
        .rst_b    (rst_b),
        .clr      (guard_c),
        .load     (guard_c),
        .ratio    (cpuclk_div_sel),
        .cpuclk   (cpuclk)
    );

    // Switch sequencer: drop the old source, hold both off, then raise the new one.
    always_comb begin
        state_d = state_q;
        gcnt_d  = '0;
        tap_d   = tap_q;
        hs_req  = 1'b0;
        ls_req  = 1'b0;
        case (state_q)
            LS_RUN: begin
                ls_req = 1'b1;
                if (sel_s) state_d = LS_OFF_WAIT;
            end
            LS_OFF_WAIT: begin
                if (!ls_en_q) state_d = GUARD;
            end
            GUARD: begin
                tap_d = TAP_W'(clamp_tap(32'(delay_sel), DEL_PIPE_SZ));
                if (32'(gcnt_q) == GUARD_CYC - 32'd1) begin
                    state_d = sel_s ? HS_ON_WAIT : LS_ON_WAIT;
                end else begin
                    gcnt_d = gcnt_q + GCNT_W'(1);
                end
            end
            HS_ON_WAIT: begin
                hs_req = 1'b1;
                if (hs_en_q) state_d = HS_RUN;
            end
            HS_RUN: begin
                hs_req = 1'b1;
                if (!sel_s) state_d = HS_OFF_WAIT;
            end
            HS_OFF_WAIT: begin
                if (!hs_en_q) state_d = GUARD;
            end
            LS_ON_WAIT: begin
                ls_req = 1'b1;
                if (ls_en_q) state_d = LS_RUN;
            end
            default: state_d = LS_RUN;
        endcase

        sync_d   = SYNC_STAGES'({sync_q, hsclk_sel});
        del_d    = DEL_PIPE_SZ'({del_q, lsclk_in});
        hs_sel_d = (state_d == HS_RUN);
        ls_sel_d = (state_d == LS_RUN);
        busy_d   = !((state_d == HS_RUN) || (state_d == LS_RUN));
        // An enable may only move while its source sits low.
        hs_en_d  = cpuclk ? hs_en_q : hs_req;
        ls_en_d  = lsclk_del ? ls_en_q : ls_req;
    end

    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= LS_RUN;
            sync_q   <= '0;
            del_q    <= '0;
            tap_q    <= TAP_W'(DEF_TAP);
            gcnt_q   <= '0;
            hs_sel_q <= 1'b0;
            ls_sel_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            del_q    <= del_d;
            tap_q    <= tap_d;
            gcnt_q   <= gcnt_d;
            hs_sel_q <= hs_sel_d;
            ls_sel_q <= ls_sel_d;
            busy_q   <= busy_d;
        end
    end

    // Enables update mid low-phase, half a cycle away from any source edge.
    always_ff @(negedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            hs_en_q <= 1'b0;
            ls_en_q <= 1'b1;
        end else begin
            hs_en_q <= hs_en_d;
            ls_en_q <= ls_en_d;
        end
    end

    assign clkout         = (cpuclk & hs_en_q) | (lsclk_del & ls_en_q);
    assign hsclk_selected = hs_sel_q;
    assign lsclk_selected = ls_sel_q;
    assign switch_busy    = busy_q;

endmodule

// File: tb/tb_clkctrl_phi2_gen.sv
// Self-checking bench for clkctrl_phi2_gen: scenario table plus hand-written
// abort and reset sequences, with a history scoreboard for the LS delay path.
`timescale 1ns/1ps
module tb_clkctrl_phi2_gen;
    import clkctrl_pkg::*;

    localparam int DEL_PIPE_SZ = 4;
    localparam int DEF_TAP     = 1;
    localparam int NV          = 8;

    logic       hsclk_in;
    logic       rst_b;
    logic       lsclk_in;
    logic       hsclk_sel;
    logic [1:0] delay_sel;
    logic [1:0] cpuclk_div_sel;
    logic       hsclk_selected;
    logic       lsclk_selected;
    logic       switch_busy;
    logic       clkout;

    clkctrl_phi2_gen dut (
        .hsclk_in       (hsclk_in),
        .rst_b          (rst_b),
        .lsclk_in       (lsclk_in),
        .hsclk_sel      (hsclk_sel),
        .delay_sel      (delay_sel),
        .cpuclk_div_sel (cpuclk_div_sel),
        .hsclk_selected (hsclk_selected),
        .lsclk_selected (lsclk_selected),
        .switch_busy    (switch_busy),
        .clkout         (clkout)
    );

    initial hsclk_in = 1'b0;
    always #5 hsclk_in = ~hsclk_in;

    typedef struct {
        logic       sel;
        logic [1:0] dsel;
        logic [1:0] div;
        int         cyc;
        logic       e_hs;
        logic       e_ls;
        logic       e_busy;
    } vec_t;

    vec_t vec [NV];

    int   n_tests = 0;
    int   n_fail  = 0;
    logic hist [$];
    int   cur_tap;
    int   cur_div;
    int   ls_ph;
    bit   mon_en = 1'b0;
    bit   hs_started, hs_valid;
    int   hs_run;
    int   n_hs_runs = 0;
    logic prev_t;
    logic prev_clk = 1'b0;
    bit   armed = 1'b0;
    int   hi_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One hsclk_in cycle: sample after the posedge, then drive the next host-clock level.
    task automatic tick();
        @(posedge hsclk_in);
        #2;
        if (switch_busy) begin
            cur_tap = (int'(delay_sel) > DEL_PIPE_SZ - 1) ? DEL_PIPE_SZ - 1 : int'(delay_sel);
            cur_div = int'(cpuclk_div_sel);
        end
        check("sel_excl", 32'(hsclk_selected & lsclk_selected), 32'd0);
        if (rst_b && lsclk_selected) begin
            check("ls_latency", 32'(clkout), 32'(hist[hist.size() - 1 - cur_tap]));
        end
        if (hsclk_selected) begin
            if (hs_started && clkout == prev_t) begin
                hs_run++;
            end else begin
                if (hs_valid) begin
                    check("hs_phase", 32'(hs_run), 32'(cur_div + 1));
                    n_hs_runs++;
                end
                hs_valid   = hs_started;
                hs_started = 1'b1;
                hs_run     = 1;
            end
        end else begin
            hs_started = 1'b0;
            hs_valid   = 1'b0;
        end
        prev_t = clkout;
        ls_ph    = (ls_ph + 1) % 8;
        lsclk_in = (ls_ph >= 4);
        hist.push_back(lsclk_in);
        if (hist.size() > 16) void'(hist.pop_front());
    endtask

    // Half-cycle monitor: full-phase high pulses only, never both enables on.
    always begin
        @(hsclk_in);
        #2;
        if (!mon_en) begin
            armed  = 1'b0;
            hi_len = 0;
        end else if (clkout && !prev_clk) begin
            armed  = 1'b1;
            hi_len = 1;
        end else if (clkout) begin
            hi_len++;
        end else if (prev_clk && armed) begin
            check("pulse_len", 32'(hi_len), (hi_len == 8) ? 32'd8 : 32'(2 * (cur_div + 1)));
        end
        prev_clk = clkout;
        if (mon_en) check("en_overlap", 32'(dut.hs_en_q & dut.ls_en_q), 32'd0);
    end

    initial begin
        bit got, saw_lsow, saw_hs;
        int runs0;

        vec[0] = '{1'b0, 2'd1, 2'd1, 20, 1'b0, 1'b1, 1'b0};
        vec[1] = '{1'b1, 2'd1, 2'd1, 30, 1'b1, 1'b0, 1'b0};
        vec[2] = '{1'b0, 2'd1, 2'd1, 30, 1'b0, 1'b1, 1'b0};
        vec[3] = '{1'b1, 2'd1, 2'd0, 30, 1'b1, 1'b0, 1'b0};
        vec[4] = '{1'b0, 2'd1, 2'd0, 30, 1'b0, 1'b1, 1'b0};
        vec[5] = '{1'b0, 2'd3, 2'd0, 20, 1'b0, 1'b1, 1'b0};
        vec[6] = '{1'b1, 2'd3, 2'd0, 30, 1'b1, 1'b0, 1'b0};
        vec[7] = '{1'b0, 2'd3, 2'd0, 30, 1'b0, 1'b1, 1'b0};

        rst_b          = 1'b0;
        lsclk_in       = 1'b0;
        hsclk_sel      = 1'b0;
        delay_sel      = 2'd1;
        cpuclk_div_sel = 2'd1;
        cur_tap        = DEF_TAP;
        cur_div        = 0;
        ls_ph          = 0;
        hs_started     = 1'b0;
        hs_valid       = 1'b0;
        hs_run         = 0;
        prev_t         = 1'b0;
        repeat (9) hist.push_back(1'b0);

        repeat (3) @(posedge hsclk_in);
        #2;
        rst_b = 1'b1;
        #1;
        check("rst_ls_sel", 32'(lsclk_selected), 32'd1);
        check("rst_hs_sel", 32'(hsclk_selected), 32'd0);
        check("rst_busy", 32'(switch_busy), 32'd0);
        check("rst_clkout", 32'(clkout), 32'd0);
        mon_en = 1'b1;

        for (int r = 0; r < NV; r++) begin
            hsclk_sel      = vec[r].sel;
            delay_sel      = vec[r].dsel;
            cpuclk_div_sel = vec[r].div;
            runs0          = n_hs_runs;
            repeat (vec[r].cyc) tick();
            check($sformatf("row%0d_hs_sel", r), 32'(hsclk_selected), 32'(vec[r].e_hs));
            check($sformatf("row%0d_ls_sel", r), 32'(lsclk_selected), 32'(vec[r].e_ls));
            check($sformatf("row%0d_busy", r), 32'(switch_busy), 32'(vec[r].e_busy));
            if (vec[r].e_hs) check($sformatf("row%0d_hs_toggle", r), 32'(n_hs_runs > runs0), 32'd1);
        end

        // Request reversed before the guard expires: must fall back to LS.
        hsclk_sel = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = switch_busy;
        end
        check("abort_busy", 32'(got), 32'd1);
        hsclk_sel = 1'b0;
        got = 1'b0;
        saw_lsow = 1'b0;
        saw_hs = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (dut.state_q == LS_ON_WAIT) saw_lsow = 1'b1;
            if (dut.hs_en_q || dut.state_q == HS_ON_WAIT || hsclk_selected) saw_hs = 1'b1;
            got = lsclk_selected;
        end
        check("abort_ls_back", 32'(got), 32'd1);
        check("abort_ls_on_wait", 32'(saw_lsow), 32'd1);
        check("abort_no_hs", 32'(saw_hs), 32'd0);

        // Reset while the HS clock is high.
        hsclk_sel = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = hsclk_selected;
        end
        check("rst_hs_reached", 32'(got), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = clkout;
        end
        check("rst_cpu_high", 32'(got), 32'd1);
        mon_en    = 1'b0;
        rst_b     = 1'b0;
        hsclk_sel = 1'b0;
        #1;
        check("mid_rst_hs_en", 32'(dut.hs_en_q), 32'd0);
        check("mid_rst_ls_en", 32'(dut.ls_en_q), 32'd1);
        check("mid_rst_state", 32'(dut.state_q), 32'(LS_RUN));
        check("mid_rst_hs_sel", 32'(hsclk_selected), 32'd0);
        check("mid_rst_ls_sel", 32'(lsclk_selected), 32'd1);
        repeat (3) tick();
        rst_b = 1'b1;
        hist.delete();
        repeat (8) hist.push_back(1'b0);
        hist.push_back(lsclk_in);
        cur_tap = DEF_TAP;
        cur_div = 0;
        repeat (12) tick();
        mon_en = 1'b1;
        repeat (20) tick();
        check("post_rst_ls_sel", 32'(lsclk_selected), 32'd1);
        check("post_rst_busy", 32'(switch_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
